// File: rtl/alu_responder.sv
// Handshaked, registered ALU responder with an iterative shift-add multiplier.
// Build option ALU_SIGNED_CMP_EN selects a signed compare for 'greater' (unsigned by default).
//   state   | meaning
//   IDLE    | ready for a request; req_ready=1
//   MUL     | shift-add multiply running, one partial product per cycle
//   RESP    | result presented; waiting for rsp_ready
module alu_responder #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       fxn,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] ans,
    output logic             cout,
    output logic             over_flow,
    output logic             greater
);

    localparam int MSB = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_RESP
    } state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] prod, prod_nxt;
    logic [2*WIDTH-1:0] mcand, mcand_nxt;
    logic [WIDTH-1:0]   mplier, mplier_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               gt_hold, gt_hold_nxt;

    logic [WIDTH-1:0]   ans_nxt;
    logic               cout_nxt, ovf_nxt, gt_nxt, rsp_valid_nxt;

    logic               accept;
    logic               cmp_gt;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_ans;
    logic               alu_cout, alu_ovf;
    logic [2*WIDTH-1:0] mul_sum;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid & req_ready;

`ifdef ALU_SIGNED_CMP_EN
    assign cmp_gt = $signed(a) > $signed(b);
`else
    assign cmp_gt = a > b;
`endif

    // Single-cycle opcodes are evaluated straight from the request port at the accept edge.
    always_comb begin
        alu_ans  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        case (fxn)
            3'b000: begin
                alu_ans  = sum[MSB:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            3'b001: begin
                alu_ans  = diff[MSB:0];
                alu_cout = diff[WIDTH];
                alu_ovf  = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            3'b010: alu_ans = a & b;
            3'b011: alu_ans = a | b;
            3'b100: alu_ans = a ^ b;
            3'b101: alu_ans = ~a;
            3'b110: begin
                alu_ans  = {a[MSB-1:0], 1'b0};
                alu_cout = a[MSB];
                alu_ovf  = a[MSB] ^ a[MSB-1];
            end
            default: begin
                alu_ans  = '0;
                alu_cout = 1'b0;
                alu_ovf  = 1'b0;
            end
        endcase
    end

    assign mul_sum = prod + (mplier[0] ? mcand : '0);

    always_comb begin
        state_nxt     = state;
        prod_nxt      = prod;
        mcand_nxt     = mcand;
        mplier_nxt    = mplier;
        cnt_nxt       = cnt;
        gt_hold_nxt   = gt_hold;
        ans_nxt       = ans;
        cout_nxt      = cout;
        ovf_nxt       = over_flow;
        gt_nxt        = greater;
        rsp_valid_nxt = rsp_valid;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    mcand_nxt   = {{WIDTH{1'b0}}, a};
                    mplier_nxt  = b;
                    prod_nxt    = '0;
                    cnt_nxt     = CNT_INIT;
                    gt_hold_nxt = cmp_gt;
                    if (fxn == OP_MUL) begin
                        state_nxt = ST_MUL;
                    end else begin
                        state_nxt     = ST_RESP;
                        ans_nxt       = alu_ans;
                        cout_nxt      = alu_cout;
                        ovf_nxt       = alu_ovf;
                        gt_nxt        = cmp_gt;
                        rsp_valid_nxt = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                prod_nxt   = mul_sum;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                cnt_nxt    = cnt - CNT_ONE;
                // Last partial product lands this cycle; publish it directly.
                if (cnt == CNT_ONE) begin
                    state_nxt     = ST_RESP;
                    ans_nxt       = mul_sum[MSB:0];
                    cout_nxt      = |mul_sum[2*WIDTH-1:WIDTH];
                    ovf_nxt       = |mul_sum[2*WIDTH-1:WIDTH];
                    gt_nxt        = gt_hold;
                    rsp_valid_nxt = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt     = ST_IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            gt_hold   <= 1'b0;
            ans       <= '0;
            cout      <= 1'b0;
            over_flow <= 1'b0;
            greater   <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            prod      <= prod_nxt;
            mcand     <= mcand_nxt;
            mplier    <= mplier_nxt;
            cnt       <= cnt_nxt;
            gt_hold   <= gt_hold_nxt;
            ans       <= ans_nxt;
            cout      <= cout_nxt;
            over_flow <= ovf_nxt;
            greater   <= gt_nxt;
            rsp_valid <= rsp_valid_nxt;
        end
    end

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed vectors, stall, reset mid-multiply,
// randomized ops and back-to-back streaming against an arithmetic reference model.
module tb_alu_responder;

    localparam int W = 6;
    localparam int MOD = 1 << W;
    localparam int HALF = 1 << (W - 1);
    localparam int TMO = 60;
`ifdef ALU_SIGNED_CMP_EN
    localparam logic SIGNED_BUILD = 1'b1;
`else
    localparam logic SIGNED_BUILD = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   fxn;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] ans;
    logic         cout;
    logic         over_flow;
    logic         greater;

    int n_cmp = 0;
    int n_err = 0;

    alu_responder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .fxn       (fxn),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .ans       (ans),
        .cout      (cout),
        .over_flow (over_flow),
        .greater   (greater)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result packed as {greater, over_flow, cout, ans}, computed with plain integer arithmetic.
    function automatic logic [W+2:0] ref_model(input int ua, input int ub, input int f);
        int r, s, sa, sb, rm;
        logic c, v, g;
        logic [31:0] rv;
        sa = (ua >= HALF) ? ua - MOD : ua;
        sb = (ub >= HALF) ? ub - MOD : ub;
        c = 1'b0;
        v = 1'b0;
        case (f)
            0: begin r = ua + ub; c = (r >= MOD); s = sa + sb; v = (s >= HALF) || (s < -HALF); end
            1: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s >= HALF) || (s < -HALF); end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            5: r = MOD - 1 - ua;
            6: begin r = ua * 2; c = (r >= MOD); s = sa * 2; v = (s >= HALF) || (s < -HALF); end
            default: begin r = ua * ub; c = (r >= MOD); v = c; end
        endcase
        rm = ((r % MOD) + MOD) % MOD;
        rv = rm;
        g = SIGNED_BUILD ? (sa > sb) : (ua > ub);
        return {g, v, c, rv[W-1:0]};
    endfunction

    // Presents one request, then scrambles the request port; leaves the response un-taken.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2:0] f,
                         output int lat, output int rdy_high);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        a = ia;
        b = ib;
        fxn = f;
        @(negedge clk);
        req_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        fxn = 3'($urandom);
        lat = 1;
        rdy_high = 0;
        while (!rsp_valid && lat < TMO) begin
            if (req_ready) rdy_high++;
            @(negedge clk);
            lat++;
        end
        if (req_ready) rdy_high++;
    endtask

    task automatic take(input int stall);
        repeat (stall) @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        a = '0;
        b = '0;
        fxn = '0;
        #3;
        n_cmp += 3;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        if ({greater, over_flow, cout, ans} !== '0) begin
            n_err++; $display("FAIL reset_outputs got=%b exp=0", {greater, over_flow, cout, ans});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors;
        int lat, rh;
        issue(6'b011100, 6'b101100, 3'b000, lat, rh);
        n_cmp += 2;
        if (lat !== 1) begin n_err++; $display("FAIL add_latency got=%0d exp=1", lat); end
        if ({greater, over_flow, cout, ans} !== {SIGNED_BUILD, 1'b0, 1'b1, 6'b001000}) begin
            n_err++; $display("FAIL add_vector got=%b exp=%b", {greater, over_flow, cout, ans},
                              {SIGNED_BUILD, 1'b0, 1'b1, 6'b001000});
        end
        take(0);
        issue(6'b001111, 6'b101100, 3'b001, lat, rh);
        n_cmp += 2;
        if (lat !== 1) begin n_err++; $display("FAIL sub_latency got=%0d exp=1", lat); end
        if ({greater, over_flow, cout, ans} !== {SIGNED_BUILD, 1'b1, 1'b1, 6'b100011}) begin
            n_err++; $display("FAIL sub_vector got=%b exp=%b", {greater, over_flow, cout, ans},
                              {SIGNED_BUILD, 1'b1, 1'b1, 6'b100011});
        end
        take(0);
        issue(6'b011000, 6'b101010, 3'b111, lat, rh);
        n_cmp += 3;
        if (lat !== W + 1) begin n_err++; $display("FAIL mul_latency got=%0d exp=%0d", lat, W + 1); end
        if (rh !== 0) begin n_err++; $display("FAIL mul_req_ready_busy got=%0d exp=0", rh); end
        if ({over_flow, cout, ans} !== {1'b1, 1'b1, 6'b110000}) begin
            n_err++; $display("FAIL mul_vector got=%b exp=%b", {over_flow, cout, ans}, {1'b1, 1'b1, 6'b110000});
        end
        take(0);
    endtask

    task automatic test_stall;
        int lat, rh, bad;
        issue(6'b110110, 6'b110000, 3'b010, lat, rh);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || ans !== 6'b110000 || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold cyc=%0d got v=%b ans=%b rdy=%b exp v=1 ans=110000 rdy=0",
                         i, rsp_valid, ans, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp += 2;
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_drop got=%b exp=0", rsp_valid); end
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL stall_idle got=%b exp=1", req_ready); end
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL stall_single_handshake got=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid_mul;
        int stale;
        @(negedge clk);
        req_valid = 1'b1;
        a = 6'b111111;
        b = 6'b111111;
        fxn = 3'b111;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 2;
        if ({rsp_valid, greater, over_flow, cout, ans} !== '0) begin
            n_err++; $display("FAIL midmul_async_clear got=%b exp=0", {rsp_valid, greater, over_flow, cout, ans});
        end
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL midmul_ready_in_reset got=%b exp=1", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        n_cmp += 2;
        if (stale !== 0) begin n_err++; $display("FAIL midmul_stale_rsp got=%0d exp=0", stale); end
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL midmul_ready_after got=%b exp=1", req_ready); end
    endtask

    task automatic test_random;
        int lat, rh, ua, ub, f, exp_lat;
        logic [W+2:0] exp;
        for (int i = 0; i < 40; i++) begin
            ua = $urandom_range(MOD - 1);
            ub = $urandom_range(MOD - 1);
            f = $urandom_range(7);
            exp = ref_model(ua, ub, f);
            exp_lat = (f == 7) ? W + 1 : 1;
            issue(W'(ua), W'(ub), 3'(f), lat, rh);
            n_cmp += 2;
            if (lat !== exp_lat) begin
                n_err++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", f, lat, exp_lat);
            end
            if ({greater, over_flow, cout, ans} !== exp) begin
                n_err++; $display("FAIL rand_result a=%0d b=%0d op=%0d got=%b exp=%b",
                                  ua, ub, f, {greater, over_flow, cout, ans}, exp);
            end
            take($urandom_range(2));
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 10;
        logic [W-1:0] qa[N];
        logic [W-1:0] qb[N];
        logic [2:0]   qf[N];
        logic [W+2:0] expq[$];
        int sent, got, cyc, last_acc, min_gap;
        for (int i = 0; i < N; i++) begin
            qa[i] = W'($urandom);
            qb[i] = W'($urandom);
            qf[i] = (i % 3 == 2) ? 3'b111 : 3'($urandom_range(6));
        end
        sent = 0;
        got = 0;
        cyc = 0;
        last_acc = -100;
        min_gap = 1000;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        a = qa[0];
        b = qb[0];
        fxn = qf[0];
        while (got < N && cyc < 400) begin
            if (rsp_valid) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra_rsp got=%b exp=none", {greater, over_flow, cout, ans});
                end else begin
                    if ({greater, over_flow, cout, ans} !== expq[0]) begin
                        n_err++; $display("FAIL b2b_result idx=%0d got=%b exp=%b", got,
                                          {greater, over_flow, cout, ans}, expq[0]);
                    end
                    void'(expq.pop_front());
                end
                got++;
            end
            if (sent < N) begin
                a = qa[sent];
                b = qb[sent];
                fxn = qf[sent];
                if (req_ready) begin
                    expq.push_back(ref_model(int'(qa[sent]), int'(qb[sent]), int'(qf[sent])));
                    if (cyc - last_acc < min_gap) min_gap = cyc - last_acc;
                    last_acc = cyc;
                    sent++;
                end
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        n_cmp += 3;
        if (got !== N) begin n_err++; $display("FAIL b2b_count got=%0d exp=%0d", got, N); end
        if (sent !== N) begin n_err++; $display("FAIL b2b_accepts got=%0d exp=%0d", sent, N); end
        if (min_gap < 2) begin n_err++; $display("FAIL b2b_spacing got=%0d exp>=2", min_gap); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stall();
        test_reset_mid_mul();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
